// File: rtl/id_pkg.sv
// Shared decode definitions for the RV32I ID stage: opcodes, func7 values,
// ALU operation codes and the decode result record.
package id_pkg;

   // Widest datapath the decode record can carry; narrower stages use the low bits.
   localparam int XLEN_MAX = 64;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   typedef struct packed {
      logic [XLEN_MAX-1:0] op1;
      logic [XLEN_MAX-1:0] op2;
      logic [4:0]          rd;
      logic                wen;
      alu_op_e             alu_op;
      logic                illegal;
   } dec_t;

   // func3 -> ALU op; 'alt' selects SUB/SRA where func7 picks the variant.
   function automatic alu_op_e base_alu(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decode (OP-IMM, OP, LUI, AUIPC) with optional
// same-cycle writeback forwarding into the source operands.
module id_decode
   import id_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic [31:0]     i_inst,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic            i_wb_wen,
   input  logic [4:0]      i_wb_addr,
   input  logic [XLEN-1:0] i_wb_data,
   output logic [4:0]      o_rs1_addr,
   output logic [4:0]      o_rs2_addr,
   output dec_t            o_dec
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_i_imm;
   logic [XLEN-1:0] w_u_imm;
   logic [XLEN-1:0] w_shamt;
   logic            w_fwd1;
   logic            w_fwd2;
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;
   logic            w_legal;
   logic            w_use1;
   logic            w_use2;
   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;
   alu_op_e         w_alu;

   assign w_opcode = i_inst[6:0];
   assign w_f3     = i_inst[14:12];
   assign w_f7     = i_inst[31:25];
   assign w_rs1    = i_inst[19:15];
   assign w_rs2    = i_inst[24:20];
   assign w_rd     = i_inst[11:7];
   assign w_i_imm  = XLEN'($signed(i_inst[31:20]));
   assign w_u_imm  = XLEN'($signed({i_inst[31:12], 12'b0}));
   assign w_shamt  = XLEN'(i_inst[24:20]);

   // x0 is never forwarded: a write to it is architecturally discarded.
   assign w_fwd1    = BYPASS_EN && i_wb_wen && (i_wb_addr != 5'd0) && (i_wb_addr == w_rs1);
   assign w_fwd2    = BYPASS_EN && i_wb_wen && (i_wb_addr != 5'd0) && (i_wb_addr == w_rs2);
   assign w_rs1_val = w_fwd1 ? i_wb_data : i_rs1_data;
   assign w_rs2_val = w_fwd2 ? i_wb_data : i_rs2_data;

   always_comb begin
      w_legal = 1'b0;
      w_use1  = 1'b0;
      w_use2  = 1'b0;
      w_op1   = '0;
      w_op2   = '0;
      w_alu   = ALU_ADD;
      case (w_opcode)
         OP_IMM: begin
            w_use1  = 1'b1;
            w_op1   = w_rs1_val;
            w_op2   = (w_f3 == 3'b001 || w_f3 == 3'b101) ? w_shamt : w_i_imm;
            w_alu   = base_alu(w_f3, (w_f3 == 3'b101) && (w_f7 == F7_ALT));
            w_legal = !((w_f3 == 3'b001 && w_f7 != F7_BASE) ||
                        (w_f3 == 3'b101 && w_f7 != F7_BASE && w_f7 != F7_ALT));
         end
         OP: begin
            w_use1  = 1'b1;
            w_use2  = 1'b1;
            w_op1   = w_rs1_val;
            w_op2   = w_rs2_val;
            w_alu   = base_alu(w_f3, w_f7 == F7_ALT);
            w_legal = (w_f7 == F7_BASE) ||
                      (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101));
         end
         LUI: begin
            w_op2   = w_u_imm;
            w_legal = 1'b1;
         end
         AUIPC: begin
            w_op1   = i_pc;
            w_op2   = w_u_imm;
            w_legal = 1'b1;
         end
         default: ;
      endcase
      // Illegal encodings still flow down the pipe, but as an inert bubble-like op.
      if (!w_legal) begin
         w_use1 = 1'b0;
         w_use2 = 1'b0;
         w_op1  = '0;
         w_op2  = '0;
         w_alu  = ALU_ADD;
      end
   end

   assign o_rs1_addr    = w_use1 ? w_rs1 : 5'd0;
   assign o_rs2_addr    = w_use2 ? w_rs2 : 5'd0;
   assign o_dec.op1     = XLEN_MAX'(w_op1);
   assign o_dec.op2     = XLEN_MAX'(w_op2);
   assign o_dec.rd      = w_legal ? w_rd : 5'd0;
   assign o_dec.wen     = w_legal && (w_rd != 5'd0);
   assign o_dec.alu_op  = w_alu;
   assign o_dec.illegal = !w_legal;

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: combinational decode feeding an ID/EX register with
// valid/ready handshakes on both sides and a flush for redirects.
module id_stage
   import id_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] inst_addr_i,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic            wb_wen_i,
   input  logic [4:0]      wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            flush_i,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     inst_o,
   output logic [XLEN-1:0] inst_addr_o,
   output logic [XLEN-1:0] op_num1_o,
   output logic [XLEN-1:0] op_num2_o,
   output logic [4:0]      rd_addr_o,
   output logic            reg_wen,
   output logic [3:0]      alu_op_o,
   output logic            illegal_o
);

   dec_t            w_dec;
   logic            w_accept;
   logic            r_valid;
   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_op1;
   logic [XLEN-1:0] r_op2;
   logic [4:0]      r_rd;
   logic            r_wen;
   logic [3:0]      r_alu;
   logic            r_illegal;

   id_decode #(
      .XLEN      (XLEN),
      .BYPASS_EN (BYPASS_EN)
   ) u_decode (
      .i_inst     (inst_i),
      .i_pc       (inst_addr_i),
      .i_rs1_data (rs1_data_i),
      .i_rs2_data (rs2_data_i),
      .i_wb_wen   (wb_wen_i),
      .i_wb_addr  (wb_addr_i),
      .i_wb_data  (wb_data_i),
      .o_rs1_addr (rs1_addr_o),
      .o_rs2_addr (rs2_addr_o),
      .o_dec      (w_dec)
   );

   generate
      if (XLEN < XLEN_MAX) begin : g_narrow
         logic w_unused_hi;
         assign w_unused_hi = ^{w_dec.op1[XLEN_MAX-1:XLEN], w_dec.op2[XLEN_MAX-1:XLEN]};
      end
   endgenerate

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   // Flush beats acceptance: the upstream handshake completes but the word is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_inst    <= '0;
         r_pc      <= '0;
         r_op1     <= '0;
         r_op2     <= '0;
         r_rd      <= '0;
         r_wen     <= 1'b0;
         r_alu     <= '0;
         r_illegal <= 1'b0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_inst    <= inst_i;
         r_pc      <= inst_addr_i;
         r_op1     <= w_dec.op1[XLEN-1:0];
         r_op2     <= w_dec.op2[XLEN-1:0];
         r_rd      <= w_dec.rd;
         r_wen     <= w_dec.wen;
         r_alu     <= w_dec.alu_op;
         r_illegal <= w_dec.illegal;
      end else if (r_valid && out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign inst_o      = r_inst;
   assign inst_addr_o = r_pc;
   assign op_num1_o   = r_op1;
   assign op_num2_o   = r_op2;
   assign rd_addr_o   = r_rd;
   assign reg_wen     = r_wen;
   assign alu_op_o    = r_alu;
   assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a behavioural decode/handshake model plus
// hand-computed expectations, with bypass on and off instances in parallel.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] inst_i = '0;
   logic [31:0] inst_addr_i = '0;
   logic [31:0] rs1_data_i = '0;
   logic [31:0] rs2_data_i = '0;
   logic        wb_wen_i = 1'b0;
   logic [4:0]  wb_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        flush_i = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, reg_wen, illegal_o;
   logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
   logic [31:0] inst_o, inst_addr_o, op_num1_o, op_num2_o;
   logic [3:0]  alu_op_o;

   logic        in_ready_nb, out_valid_nb, reg_wen_nb, illegal_nb;
   logic [4:0]  rs1_addr_nb, rs2_addr_nb, rd_addr_nb;
   logic [31:0] inst_nb, inst_addr_nb, op1_nb, op2_nb;
   logic [3:0]  alu_op_nb;

   int n_err = 0;
   int n_chk = 0;
   bit armed = 1'b0;

   always #5 clk = ~clk;

   id_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .wb_wen_i(wb_wen_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .op_num1_o(op_num1_o), .op_num2_o(op_num2_o),
      .rd_addr_o(rd_addr_o), .reg_wen(reg_wen), .alu_op_o(alu_op_o),
      .illegal_o(illegal_o)
   );

   id_stage #(.XLEN(32), .BYPASS_EN(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nb),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .rs1_addr_o(rs1_addr_nb), .rs2_addr_o(rs2_addr_nb),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .wb_wen_i(wb_wen_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .flush_i(flush_i), .out_valid(out_valid_nb), .out_ready(out_ready),
      .inst_o(inst_nb), .inst_addr_o(inst_addr_nb),
      .op_num1_o(op1_nb), .op_num2_o(op2_nb),
      .rd_addr_o(rd_addr_nb), .reg_wen(reg_wen_nb), .alu_op_o(alu_op_nb),
      .illegal_o(illegal_nb)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic        wen;
      logic [3:0]  alu;
      logic        ill;
   } exp_t;

   // ALU code by func3 for the non-alternate variant (ADD SLL SLT SLTU XOR SRL OR AND)
   int alu_of_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic wen, input logic [4:0] wa,
                                  input logic [31:0] wd, input bit byp);
      exp_t        e;
      logic [31:0] v1, v2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      bit          ok;
      e  = '0;
      f3 = inst[14:12];
      f7 = inst[31:25];
      v1 = (byp && wen && wa != 0 && wa == inst[19:15]) ? wd : d1;
      v2 = (byp && wen && wa != 0 && wa == inst[24:20]) ? wd : d2;
      ok = 1'b0;
      if (inst[6:0] == 7'h13) begin
         ok = !((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20));
         e.op1 = v1;
         e.op2 = (f3 == 1 || f3 == 5) ? {27'b0, inst[24:20]} : {{20{inst[31]}}, inst[31:20]};
         e.alu = (f3 == 5 && f7 == 7'h20) ? 4'd7 : 4'(alu_of_f3[f3]);
         e.a1  = inst[19:15];
      end else if (inst[6:0] == 7'h33) begin
         ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
         e.op1 = v1;
         e.op2 = v2;
         e.alu = (f7 == 7'h20) ? ((f3 == 0) ? 4'd1 : 4'd7) : 4'(alu_of_f3[f3]);
         e.a1  = inst[19:15];
         e.a2  = inst[24:20];
      end else if (inst[6:0] == 7'h37 || inst[6:0] == 7'h17) begin
         ok = 1'b1;
         e.op1 = (inst[6:0] == 7'h17) ? pc : 32'd0;
         e.op2 = {inst[31:12], 12'h000};
         e.alu = 4'd0;
      end
      if (ok) begin
         e.rd  = inst[11:7];
         e.wen = (inst[11:7] != 0);
      end else begin
         e     = '0;
         e.ill = 1'b1;
      end
      return e;
   endfunction

   logic        m_valid;
   logic [31:0] m_inst, m_pc;
   exp_t        m_q, m_qnb;

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_inst  <= '0;
         m_pc    <= '0;
         m_q     <= '0;
         m_qnb   <= '0;
      end else if (flush_i) begin
         m_valid <= 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
         m_valid <= 1'b1;
         m_inst  <= inst_i;
         m_pc    <= inst_addr_i;
         m_q     <= model(inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
                          wb_wen_i, wb_addr_i, wb_data_i, 1'b1);
         m_qnb   <= model(inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
                          wb_wen_i, wb_addr_i, wb_data_i, 1'b0);
      end else if (m_valid && out_ready) begin
         m_valid <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Registered outputs checked mid-cycle; combinational ones just before the edge.
   always begin
      exp_t c;
      @(negedge clk);
      if (armed) begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("inst_o", inst_o, m_inst);
         chk("inst_addr_o", inst_addr_o, m_pc);
         chk("op1", op_num1_o, m_q.op1);
         chk("op2", op_num2_o, m_q.op2);
         chk("rd", 32'(rd_addr_o), 32'(m_q.rd));
         chk("reg_wen", 32'(reg_wen), 32'(m_q.wen));
         chk("alu_op", 32'(alu_op_o), 32'(m_q.alu));
         chk("illegal", 32'(illegal_o), 32'(m_q.ill));
         chk("nb_valid", 32'(out_valid_nb), 32'(m_valid));
         chk("nb_op1", op1_nb, m_qnb.op1);
         chk("nb_op2", op2_nb, m_qnb.op2);
      end
      #4;
      if (armed) begin
         chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
         c = model(inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
                   wb_wen_i, wb_addr_i, wb_data_i, 1'b1);
         if (!c.ill) begin
            chk("rs1_addr", 32'(rs1_addr_o), 32'(c.a1));
            chk("rs2_addr", 32'(rs2_addr_o), 32'(c.a2));
            chk("nb_rs1_addr", 32'(rs1_addr_nb), 32'(c.a1));
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic v, input logic rdy);
      #1;
      inst_i = inst; inst_addr_i = pc; rs1_data_i = d1; rs2_data_i = d2;
      in_valid = v; out_ready = rdy;
      $display("step inst=%h pc=%h d1=%h d2=%h v=%0d rdy=%0d wb=%0d/x%0d/%h flush=%0d rst=%0d",
               inst, pc, d1, d2, v, rdy, wb_wen_i, wb_addr_i, wb_data_i, flush_i, rst);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      @(negedge clk);
      armed = 1'b1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_op1", op_num1_o, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      step(32'hFFB10093, 32'h0, 32'd10, 32'd0, 1, 1);          // addi x1,x2,-5
      chk("addi_op1", op_num1_o, 32'd10);
      chk("addi_op2", op_num2_o, 32'hFFFFFFFB);
      chk("addi_rd", 32'(rd_addr_o), 32'd1);
      chk("addi_wen", 32'(reg_wen), 32'd1);
      chk("addi_alu", 32'(alu_op_o), 32'd0);

      step(32'h402081B3, 32'h4, 32'd7, 32'd3, 1, 1);           // sub x3,x1,x2
      chk("sub_op1", op_num1_o, 32'd7);
      chk("sub_op2", op_num2_o, 32'd3);
      chk("sub_alu", 32'(alu_op_o), 32'd1);
      chk("sub_rd", 32'(rd_addr_o), 32'd3);

      step(32'h422081B3, 32'h8, 32'd7, 32'd3, 1, 1);           // func7 0100001
      chk("badf7_illegal", 32'(illegal_o), 32'd1);
      chk("badf7_wen", 32'(reg_wen), 32'd0);

      step(32'h123452B7, 32'hC, 32'd0, 32'd0, 1, 1);           // lui x5,0x12345
      chk("lui_op1", op_num1_o, 32'd0);
      chk("lui_op2", op_num2_o, 32'h12345000);

      step(32'h00001297, 32'h100, 32'd0, 32'd0, 1, 1);         // auipc x5,1
      chk("auipc_op1", op_num1_o, 32'h100);
      chk("auipc_op2", op_num2_o, 32'h1000);

      wb_wen_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'h100;
      step(32'hFFB10093, 32'h14, 32'd10, 32'd0, 1, 1);         // bypass of x2
      chk("byp_op1", op_num1_o, 32'h100);
      chk("nobyp_op1", op1_nb, 32'd10);

      wb_addr_i = 5'd0; wb_data_i = 32'h55;
      step(32'h00500093, 32'h18, 32'd0, 32'd0, 1, 1);          // addi x1,x0,5 with wb to x0
      chk("x0_op1", op_num1_o, 32'd0);
      chk("x0_op2", op_num2_o, 32'd5);
      wb_wen_i = 1'b0;

      step(32'h4030D213, 32'h1C, 32'h80000000, 32'd0, 1, 1);   // srai x4,x1,3
      chk("srai_alu", 32'(alu_op_o), 32'd7);
      chk("srai_op2", op_num2_o, 32'd3);

      step(32'h02009093, 32'h20, 32'd1, 32'd0, 1, 1);          // slli with func7 != 0
      chk("slli_bad", 32'(illegal_o), 32'd1);

      for (int f3 = 0; f3 < 8; f3++) begin
         logic [2:0] f;
         f = 3'(f3);
         step({7'h00, 5'd6, 5'd5, f, 5'd7, 7'h33}, 32'h24 + 32'(4 * f3),
              $urandom, $urandom, 1, 1);
         step({7'h00, 12'($urandom), 5'd9, f, 5'd10, 7'h13}, 32'h44 + 32'(4 * f3),
              $urandom, 32'd0, 1, 1);
      end

      // Backpressure: hold A for three cycles while B waits, then swap with no bubble.
      step(32'h00A00413, 32'h200, 32'd0, 32'd0, 1, 1);         // A: addi x8,x0,10
      for (int i = 0; i < 3; i++) begin
         step(32'h01400493, 32'h204, 32'd0, 32'd0, 1, 0);      // B: addi x9,x0,20
         chk("stall_inst", inst_o, 32'h00A00413);
         chk("stall_op2", op_num2_o, 32'd10);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      step(32'h01400493, 32'h204, 32'd0, 32'd0, 1, 1);
      chk("swap_inst", inst_o, 32'h01400493);
      chk("swap_valid", 32'(out_valid), 32'd1);

      flush_i = 1'b1;
      step(32'h01E00513, 32'h208, 32'd0, 32'd0, 1, 1);         // dropped by flush
      chk("flush_valid", 32'(out_valid), 32'd0);
      flush_i = 1'b0;
      step(32'h0, 32'h0, 32'd0, 32'd0, 0, 1);
      chk("flush_stay_empty", 32'(out_valid), 32'd0);

      step(32'h02800593, 32'h20C, 32'd0, 32'd0, 1, 0);         // D loads
      step(32'h03200613, 32'h210, 32'd0, 32'd0, 1, 0);         // stall
      rst = 1'b1;
      step(32'h03200613, 32'h210, 32'd0, 32'd0, 1, 0);
      chk("rst_stall_valid", 32'(out_valid), 32'd0);
      chk("rst_stall_op2", op_num2_o, 32'd0);
      chk("rst_stall_inst", inst_o, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++)
         step(32'h00C68733 + 32'(i << 7), 32'h300, $urandom, $urandom, 1'(i), 1'(i >> 1));
      step(32'h0, 32'h0, 32'd0, 32'd0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
